// File: rtl/djs130_tti_buf.sv
// djs130_tti_buf: buffered teletype-input controller for the DJS130 I/O bus.
// Keyboard chars go into a FIFO and are handed to the CPU one per Start command.
//
// Ports:
//   clk         system clock, rising edge
//   rst_1       async active-high reset
//   i_ZZ0       sync program reset (IORST)
//   i_dev_KZ    bus strobes: [3]=DIA [6]=S [7]=C [8]=MSK
//   i_msk_bit   interrupt-disable value for MSK
//   i_write     keyboard push strobe
//   i_data      keyboard character
//   o_dev_ZT    {busy, done}
//   o_dev_ZDQQ  interrupt request
//   o_dev_DMS   device code
//   o_dev_SC    data bus, r_A while DIA
//   o_overrun   sticky dropped-push flag
//   o_level     FIFO occupancy
module djs130_tti_buf #(
    parameter logic [5:0] DMS    = 6'o10,
    parameter int         DATA_W = 8,
    parameter int         DEPTH  = 16,
    parameter int         AW     = 4,
    parameter bit         MAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_1,
    input  logic              i_ZZ0,
    input  logic [8:0]        i_dev_KZ,
    input  logic              i_msk_bit,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_data,
    output logic [1:0]        o_dev_ZT,
    output logic              o_dev_ZDQQ,
    output logic [5:0]        o_dev_DMS,
    output logic [15:0]       o_dev_SC,
    output logic              o_overrun,
    output logic [AW:0]       o_level
);

    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mask_q, mask_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] ra_q, ra_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              kz_dia;
    logic              kz_s;
    logic              kz_c;
    logic              kz_msk;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] wr_data;
    logic              unused_kz;

    assign kz_dia = i_dev_KZ[3];
    assign kz_s   = i_dev_KZ[6];
    assign kz_c   = i_dev_KZ[7];
    assign kz_msk = i_dev_KZ[8];

    // Strobes this controller does not decode.
    assign unused_kz = ^{i_dev_KZ[5:4], i_dev_KZ[2:0]};

    // Optional keyboard translation: BS -> DEL, CR -> LF.
    always_comb begin
        wr_data = i_data;
        if (MAP_EN) begin
            if (i_data == DATA_W'(8)) begin
                wr_data = DATA_W'(127);
            end else if (i_data == DATA_W'(13)) begin
                wr_data = DATA_W'(10);
            end
        end
    end

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // A pop only happens on a quiet BUSY cycle; C or S that cycle take over.
    assign pop  = (state_q == ST_BUSY) && !empty && !kz_c && !kz_s;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign push = i_write && (!full || pop);
    assign drop = i_write && full && !pop;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        mask_d  = mask_q;
        ovr_d   = ovr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;

        if (kz_c) begin
            state_d = ST_IDLE;
        end else if (kz_s) begin
            state_d = ST_BUSY;
        end else if (pop) begin
            state_d = ST_DONE;
        end

        if (pop) begin
            ra_d   = mem_q[head_q];
            head_d = head_q + AW'(1);
        end

        if (push) begin
            tail_d = tail_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (kz_c) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end

        if (kz_msk) begin
            mask_d = i_msk_bit;
        end

        // Program reset behaves like rst_1, but on the clock edge.
        if (i_ZZ0) begin
            state_d = ST_IDLE;
            ra_d    = '0;
            mask_d  = 1'b0;
            ovr_d   = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end

        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst_1) begin
        if (rst_1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ra_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            ovr_q   <= ovr_d;
            ra_q    <= ra_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push && !i_ZZ0) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    assign o_dev_ZT   = {busy_q, done_q};
    assign o_dev_ZDQQ = done_q & ~mask_q;
    assign o_dev_DMS  = DMS;
    assign o_dev_SC   = kz_dia ? {{(16 - DATA_W){1'b0}}, ra_q} : 16'h0000;
    assign o_overrun  = ovr_q;
    assign o_level    = level_q;

endmodule
